// File: rtl/timer_sched_pkg.sv
// timer_sched_pkg: shared types and constants for the timer scheduler.
// Holds the FSM state encoding, the interval-timer register map, the control
// words written to it and a small helper for building bus commands.
package timer_sched_pkg;

  // Scheduler FSM states.
  typedef enum logic [3:0] {
    IDLE,
    ARB,
    WR_PL,
    WR_PH,
    WR_CTL,
    WAIT_IRQ,
    WR_STOP,
    WR_STAT,
    FIN
  } state_e;

  // Interval timer register addresses.
  localparam logic [2:0] ADDR_STATUS   = 3'd0;
  localparam logic [2:0] ADDR_CONTROL  = 3'd1;
  localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
  localparam logic [2:0] ADDR_PERIOD_H = 3'd3;

  // Control words: one-shot start with interrupt enabled, and stop.
  localparam logic [15:0] CTL_START_ITO = 16'h0005;
  localparam logic [15:0] CTL_STOP      = 16'h0008;
  // Any write to the status register clears the timeout flag.
  localparam logic [15:0] STATUS_CLEAR  = 16'h0000;

  // One registered bus cycle towards the timer slave.
  typedef struct packed {
    logic        cs;
    logic        write_n;
    logic [2:0]  addr;
    logic [15:0] data;
  } bus_cmd_t;

  localparam bus_cmd_t BUS_IDLE = '{cs: 1'b0, write_n: 1'b1, addr: 3'd0, data: 16'd0};

  // Build a single write cycle to the given timer register.
  function automatic bus_cmd_t bus_write(input logic [2:0] addr, input logic [15:0] data);
    bus_cmd_t cmd;
    cmd.cs      = 1'b1;
    cmd.write_n = 1'b0;
    cmd.addr    = addr;
    cmd.data    = data;
    return cmd;
  endfunction

  // The timer counts load+1 cycles, so a requested delay of P loads P-1.
  // A zero request is treated like a one-cycle delay.
  function automatic logic [31:0] period_to_load(input logic [31:0] period);
    return (period == 32'd0) ? 32'd0 : period - 32'd1;
  endfunction

endpackage

// File: rtl/timer_sched_if.sv
// timer_sched_if: Avalon-MM slave port of the interval timer plus its irq.
// The scheduler uses the master modport; the timer (or a model of it) uses
// the slave modport.
interface timer_sched_if;
  logic [2:0]  tmr_address;
  logic        tmr_chipselect;
  logic        tmr_write_n;
  logic [15:0] tmr_writedata;
  logic        tmr_irq;

  modport master (
    output tmr_address,
    output tmr_chipselect,
    output tmr_write_n,
    output tmr_writedata,
    input  tmr_irq
  );

  modport slave (
    input  tmr_address,
    input  tmr_chipselect,
    input  tmr_write_n,
    input  tmr_writedata,
    output tmr_irq
  );
endinterface

// File: rtl/timer_sched_rr_arb.sv
// timer_sched_rr_arb: combinational round-robin pick.
// The winner is the lowest requesting index strictly above last_i, wrapping to
// the lowest requesting index overall. The last-winner register lives in the
// caller so this block stays stateless.
module timer_sched_rr_arb #(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  input  logic [2:0]   last_i,
  output logic [2:0]   winner_o,
  output logic         valid_o
);

  logic [N-1:0] above_mask;
  logic [N-1:0] req_above;
  logic [N-1:0] pick;

  // Channels that sit strictly above the previous winner.
  for (genvar gi = 0; gi < N; gi++) begin : g_above
    assign above_mask[gi] = (3'(gi) > last_i);
  end

  assign req_above = req_i & above_mask;

  // Prefer the upper window; fall back to the full vector when it is empty,
  // then take the lowest set bit of whichever window was chosen.
  always_comb begin
    winner_o = 3'd0;
    valid_o  = |req_i;
    pick     = (|req_above) ? req_above : req_i;
    for (int i = N - 1; i >= 0; i--) begin
      if (pick[i]) begin
        winner_o = 3'(i);
      end
    end
  end

endmodule

// File: rtl/timer_sched.sv
// timer_sched: multi-requester one-shot alarm scheduler in front of the
// interval timer. A round-robin winner gets the timer programmed with its
// period, the block waits for the irq (or a cancel), clears the timeout and
// pulses done/err back to that channel.
// Optional build macro: TIMER_SCHED_WATCHDOG_EN adds a per-alarm watchdog that
// aborts an alarm whose irq is more than WD_MARGIN+4 cycles late.
module timer_sched
  import timer_sched_pkg::*;
#(
  parameter int N         = 4,
  parameter int WD_MARGIN = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N-1:0]      req,
  input  logic [N*32-1:0]   req_period,
  output logic              active,
  output logic [2:0]        grant_id,
  output logic [N-1:0]      done,
  output logic [N-1:0]      err,
  timer_sched_if.master     tmr
);

  // Unsupported parameter values leave this marker block in the hierarchy.
  if (N < 2 || N > 8 || WD_MARGIN < 0) begin : g_bad_params
  end

  state_e      state_q, state_d;
  logic [2:0]  grant_q, grant_d;
  logic [2:0]  last_q, last_d;
  logic [31:0] load_q, load_d;
  logic        abort_q, abort_d;
  logic        active_q, active_d;
  logic [N-1:0] done_q, done_d;
  logic [N-1:0] err_q, err_d;
  bus_cmd_t    bus_q, bus_d;

  logic [2:0]  arb_winner;
  logic        arb_valid;
  logic [31:0] period_arr [N];
  logic [31:0] sel_period;
  logic [N-1:0] grant_hot;
  logic        grant_req;
  logic        wd_expired;

  timer_sched_rr_arb #(.N(N)) u_arb (
    .req_i    (req),
    .last_i   (last_q),
    .winner_o (arb_winner),
    .valid_o  (arb_valid)
  );

  // Split the flat period bus and decode the owning channel one-hot.
  for (genvar gi = 0; gi < N; gi++) begin : g_chan
    assign period_arr[gi] = req_period[32*gi +: 32];
    assign grant_hot[gi]  = (grant_q == 3'(gi));
  end

  // The owner still wants its alarm while its request stays high.
  assign grant_req = |(req & grant_hot);

  // Period of the channel the arbiter is about to grant.
  always_comb begin
    sel_period = 32'd0;
    for (int i = 0; i < N; i++) begin
      if (arb_winner == 3'(i)) begin
        sel_period = period_arr[i];
      end
    end
  end

`ifdef TIMER_SCHED_WATCHDOG_EN
  logic [32:0] wd_cnt_q, wd_cnt_d;
  logic [32:0] wd_limit;

  assign wd_limit = {1'b0, load_q} + 33'(WD_MARGIN + 5);

  // Counts cycles spent in WAIT_IRQ including the current one; zero elsewhere,
  // so it restarts on every entry to WAIT_IRQ.
  always_comb begin
    wd_cnt_d = 33'd0;
    if (state_q == WAIT_IRQ) begin
      wd_cnt_d = wd_cnt_q + 33'd1;
    end
  end

  assign wd_expired = (state_q == WAIT_IRQ) && (wd_cnt_d > wd_limit);

  // Watchdog counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt_q <= 33'd0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end
`else
  assign wd_expired = 1'b0;
`endif

  // Next-state logic: arbitration, programming sequence and alarm outcome.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    load_d  = load_q;
    abort_d = abort_q;
    case (state_q)
      IDLE: begin
        if (|req) state_d = ARB;
      end
      ARB: begin
        if (arb_valid) begin
          grant_d = arb_winner;
          load_d  = period_to_load(sel_period);
          abort_d = 1'b0;
          state_d = WR_PL;
        end else begin
          state_d = IDLE;
        end
      end
      WR_PL:  state_d = WR_PH;
      WR_PH:  state_d = WR_CTL;
      WR_CTL: state_d = WAIT_IRQ;
      WAIT_IRQ: begin
        // A timeout reported in the same cycle as a cancel still counts as done.
        if (tmr.tmr_irq) begin
          state_d = WR_STAT;
        end else if (!grant_req || wd_expired) begin
          abort_d = 1'b1;
          state_d = WR_STOP;
        end
      end
      WR_STOP: state_d = WR_STAT;
      WR_STAT: state_d = FIN;
      FIN: begin
        last_d  = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs are decoded from the next state so each write state
  // owns exactly the bus cycle in which the FSM sits in it.
  always_comb begin
    bus_d    = BUS_IDLE;
    active_d = !(state_d == IDLE || state_d == ARB);
    done_d   = '0;
    err_d    = '0;
    case (state_d)
      WR_PL:   bus_d = bus_write(ADDR_PERIOD_L, load_d[15:0]);
      WR_PH:   bus_d = bus_write(ADDR_PERIOD_H, load_d[31:16]);
      WR_CTL:  bus_d = bus_write(ADDR_CONTROL, CTL_START_ITO);
      WR_STOP: bus_d = bus_write(ADDR_CONTROL, CTL_STOP);
      WR_STAT: bus_d = bus_write(ADDR_STATUS, STATUS_CLEAR);
      FIN: begin
        if (abort_d) err_d  = grant_hot;
        else         done_d = grant_hot;
      end
      default: bus_d = BUS_IDLE;
    endcase
  end

  // State and output registers; reset drops everything without touching the timer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= 3'd0;
      last_q   <= 3'(N - 1);
      load_q   <= 32'd0;
      abort_q  <= 1'b0;
      active_q <= 1'b0;
      done_q   <= '0;
      err_q    <= '0;
      bus_q    <= BUS_IDLE;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      load_q   <= load_d;
      abort_q  <= abort_d;
      active_q <= active_d;
      done_q   <= done_d;
      err_q    <= err_d;
      bus_q    <= bus_d;
    end
  end

  assign active             = active_q;
  assign grant_id           = grant_q;
  assign done               = done_q;
  assign err                = err_q;
  assign tmr.tmr_chipselect = bus_q.cs;
  assign tmr.tmr_write_n    = bus_q.write_n;
  assign tmr.tmr_address    = bus_q.addr;
  assign tmr.tmr_writedata  = bus_q.data;

endmodule

// File: tb/tb_timer_sched.sv
// tb_timer_sched: randomized self-checking bench for timer_sched.
// A behavioural interval-timer model answers the bus; a transaction-level
// model predicts round-robin winners and the write sequence of every alarm.
module tb_timer_sched;
  localparam int N         = 4;
  localparam int WD_MARGIN = 16;
  localparam int BUDGET    = 3000;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req;
  logic [N*32-1:0]  req_period;
  logic             active;
  logic [2:0]       grant_id;
  logic [N-1:0]     done;
  logic [N-1:0]     err;

  timer_sched_if bus();

  timer_sched #(.N(N), .WD_MARGIN(WD_MARGIN)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_period (req_period),
    .active     (active),
    .grant_id   (grant_id),
    .done       (done),
    .err        (err),
    .tmr        (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_m;
  logic [31:0] period_m [N];

  // Timer model state and per-cycle observations.
  logic [15:0] t_pl, t_ph;
  longint      t_cnt;
  bit          t_run, t_auto;
  bit          wr_seen, irq_rose;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [18:0] wr_q [$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_period(input int ch, input logic [31:0] p);
    req_period[ch*32 +: 32] = p;
    period_m[ch] = p;
  endtask

  task automatic tmr_reset();
    t_run = 0;
    t_pl = '0;
    t_ph = '0;
    bus.tmr_irq = 1'b0;
  endtask

  // One clock: sample at the falling edge and let the timer model react.
  task automatic tick();
    @(negedge clk);
    cyc++;
    wr_seen  = 0;
    irq_rose = 0;
    if (bus.tmr_chipselect && !bus.tmr_write_n) begin
      wr_seen = 1;
      wr_addr = bus.tmr_address;
      wr_data = bus.tmr_writedata;
      wr_q.push_back({wr_addr, wr_data});
      case (wr_addr)
        3'd0: bus.tmr_irq = 1'b0;
        3'd1: begin
          if (wr_data[3]) t_run = 0;
          if (wr_data[2]) begin
            t_cnt = longint'({t_ph, t_pl}) + 1;
            t_run = 1;
          end
        end
        3'd2: t_pl = wr_data;
        3'd3: t_ph = wr_data;
        default: ;
      endcase
    end else if (t_run && t_auto) begin
      t_cnt--;
      if (t_cnt == 0) begin
        t_run = 0;
        bus.tmr_irq = 1'b1;
        irq_rose = 1;
      end
    end
  endtask

  function automatic int rr_next(input logic [N-1:0] pend, input int last);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last + k) % N;
      if (pend[c]) return c;
    end
    return -1;
  endfunction

  // Run one alarm for channel ch.
  // mode 0: timer fires; 1: cancel k cycles after START; 2: irq and cancel
  // together k cycles after START; 3: irq withheld (watchdog).
  task automatic serve(input int ch, input int mode, input int k, input bit chk_lat);
    int t0, t_first, t_ctl, t_stop, t_irq, t_cancel, t_fin, gid;
    logic [N-1:0] done_v, err_v;
    logic act_fin;
    bit fin;
    logic [31:0] l;
    logic [18:0] exp_q [$];
    logic [31:0] exp_done, exp_err;

    l = (period_m[ch] == 0) ? 32'd0 : period_m[ch] - 32'd1;
    wr_q.delete();
    t0 = cyc; t_first = -1; t_ctl = -1; t_stop = -1; t_irq = -1; t_cancel = -1; t_fin = -1;
    gid = -1; fin = 0; done_v = '0; err_v = '0; act_fin = 1'b0;
    t_run = 0;
    t_auto = (mode == 0);
    for (int b = 0; b < BUDGET && !fin; b++) begin
      tick();
      if (wr_seen) begin
        if (t_first < 0) t_first = cyc;
        if (wr_addr == 3'd1 && wr_data == 16'h0005) t_ctl = cyc;
        if (wr_addr == 3'd1 && wr_data == 16'h0008) t_stop = cyc;
      end
      if (irq_rose) t_irq = cyc;
      if (active && gid < 0) gid = int'(grant_id);
      if ((done | err) != '0) begin
        fin = 1; done_v = done; err_v = err; act_fin = active; t_fin = cyc;
        req[ch] = 1'b0;
      end else if ((mode == 1 || mode == 2) && t_ctl >= 0 && cyc == t_ctl + k) begin
        if (mode == 2) begin
          bus.tmr_irq = 1'b1;
          t_irq = cyc;
        end
        req[ch] = 1'b0;
        t_cancel = cyc;
      end
    end
    check_val("finished", 32'(fin), 32'd1);
    req[ch] = 1'b0;
    tick();
    check_val("done_one_pulse", 32'(done), 32'd0);
    check_val("err_one_pulse", 32'(err), 32'd0);
    check_val("active_after_fin", 32'(active), 32'd0);

    exp_q.push_back({3'd2, l[15:0]});
    exp_q.push_back({3'd3, l[31:16]});
    exp_q.push_back({3'd1, 16'h0005});
    if (mode == 1 || mode == 3) exp_q.push_back({3'd1, 16'h0008});
    exp_q.push_back({3'd0, 16'h0000});
    exp_done = (mode == 0 || mode == 2) ? (32'd1 << ch) : 32'd0;
    exp_err  = (mode == 1 || mode == 3) ? (32'd1 << ch) : 32'd0;

    check_val("grant_id", 32'(gid), 32'(ch));
    check_val("write_count", 32'(wr_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      check_val($sformatf("write%0d_addr_data", i), 32'(wr_q[i]), 32'(exp_q[i]));
    end
    check_val("done_vec", 32'(done_v), exp_done);
    check_val("err_vec", 32'(err_v), exp_err);
    check_val("active_in_fin", 32'(act_fin), 32'd1);
    if (mode == 0 || mode == 2) check_val("irq_to_done", 32'(t_fin - t_irq), 32'd2);
    if (mode == 1) check_val("cancel_to_err", 32'(t_fin - t_cancel), 32'd3);
    if (mode == 3) check_val("wd_stop_time", 32'(t_stop - (t_ctl + 1)), l + 32'd1 + 32'(WD_MARGIN) + 32'd5);
    if (chk_lat) check_val("req_to_wr_pl", 32'(t_first - t0), 32'd2);
    $display("txn ch=%0d period=%0d mode=%0d done=%b err=%b writes=%0d cycles=%0d",
             ch, period_m[ch], mode, done_v, err_v, wr_q.size(), cyc - t0);
  endtask

  // Serve everything pending in model round-robin order, optionally with
  // random cancels and late arrivals.
  task automatic drain(input bit rnd);
    int w, mode, k;
    logic [N-1:0] add;
    for (int s = 0; s < 32 && req != '0; s++) begin
      w = rr_next(req, last_m);
      mode = 0; k = 0;
      if (rnd && $urandom_range(0, 3) == 0) begin
        mode = 1;
        k = int'($urandom_range(1, 5));
      end
      serve(w, mode, k, 1'b0);
      last_m = w;
      if (rnd && s < 4 && $urandom_range(0, 2) == 0) begin
        add = N'($urandom_range(0, (1 << N) - 1)) & ~req;
        for (int i = 0; i < N; i++) begin
          if (add[i]) set_period(i, 32'($urandom_range(0, 40)));
        end
        req = req | add;
      end
    end
    req = '0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_val({pfx, "_active"}, 32'(active), 32'd0);
    check_val({pfx, "_grant_id"}, 32'(grant_id), 32'd0);
    check_val({pfx, "_done"}, 32'(done), 32'd0);
    check_val({pfx, "_err"}, 32'(err), 32'd0);
    check_val({pfx, "_chipselect"}, 32'(bus.tmr_chipselect), 32'd0);
    check_val({pfx, "_write_n"}, 32'(bus.tmr_write_n), 32'd1);
    check_val({pfx, "_address"}, 32'(bus.tmr_address), 32'd0);
    check_val({pfx, "_writedata"}, 32'(bus.tmr_writedata), 32'd0);
  endtask

  initial begin
    int w;
    bit got_ctl;
    logic [N-1:0] mask;
    int rr_order [5];

    reset = 1'b1;
    req = '0;
    req_period = '0;
    for (int i = 0; i < N; i++) period_m[i] = 32'd0;
    tmr_reset();
    t_auto = 1;
    last_m = N - 1;
    repeat (3) tick();
    check_reset_outputs("reset");
    reset = 1'b0;
    tick();

    // Round robin from reset: 0,1,2,3 then channel 0 again after it re-requests.
    rr_order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < N; i++) set_period(i, 32'd10);
    req = '1;
    for (int i = 0; i < 5; i++) begin
      serve(rr_order[i], 0, 0, i == 0);
      last_m = rr_order[i];
      if (i == 0) req[0] = 1'b1;
    end

    // Single request, period 100.
    set_period(0, 32'd100);
    req[0] = 1'b1;
    serve(0, 0, 0, 1'b1);
    last_m = 0;

    // Period 0 loads 0.
    set_period(1, 32'd0);
    req[1] = 1'b1;
    serve(1, 0, 0, 1'b1);
    last_m = 1;

    // Period 0x10000 loads 0x0000_FFFF; cancelled early.
    set_period(3, 32'h0001_0000);
    req[3] = 1'b1;
    serve(3, 1, 5, 1'b1);
    last_m = 3;

    // Cancel 50 cycles into the wait of a 1000-cycle alarm.
    set_period(2, 32'd1000);
    req[2] = 1'b1;
    serve(2, 1, 50, 1'b1);
    last_m = 2;

    // irq and cancel in the same cycle: done wins, no STOP.
    set_period(1, 32'd8);
    req[1] = 1'b1;
    serve(1, 2, 3, 1'b1);
    last_m = 1;

`ifdef TIMER_SCHED_WATCHDOG_EN
    // irq withheld: watchdog aborts.
    set_period(2, 32'd20);
    req[2] = 1'b1;
    serve(2, 3, 0, 1'b1);
    last_m = 2;
`endif

    // Randomized batches.
    for (int it = 0; it < 12; it++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        if (mask[i]) set_period(i, 32'($urandom_range(0, 40)));
      end
      req = mask;
      drain(1'b1);
      tick();
    end

    // Reset while waiting for irq.
    set_period(1, 32'd50);
    set_period(2, 32'd50);
    req = 4'b0110;
    w = rr_next(req, last_m);
    wr_q.delete();
    t_run = 0;
    t_auto = 0;
    got_ctl = 0;
    for (int b = 0; b < 100 && !got_ctl; b++) begin
      tick();
      if (wr_seen && wr_addr == 3'd1) got_ctl = 1;
    end
    check_val("pre_reset_ctl_seen", 32'(got_ctl), 32'd1);
    repeat (5) tick();
    check_val("pre_reset_active", 32'(active), 32'd1);
    check_val("pre_reset_grant", 32'(grant_id), 32'(w));
    reset = 1'b1;
    tmr_reset();
    tick();
    check_reset_outputs("rst_mid");
    set_period(0, 32'd7);
    set_period(1, 32'd3);
    set_period(3, 32'd12);
    req = 4'b1011;
    reset = 1'b0;
    last_m = N - 1;
    serve(0, 0, 0, 1'b1);
    last_m = 0;
    drain(1'b0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
